dma_xfer_sequencer: RTL and testbench

Upstream control stage for the DMA bus controller. Accepts one block-transfer command (memory address, byte count, direction) and breaks it into 16-byte chunk requests over the controller's work-unit interface (MOD_EN/MOD_WR/MOD_A/MOD_WRITE_DATA in, MOD_READ_DATA/MOD_R out). Chunk data moves between those requests and the DMA's local disk buffer, so the bus controller only ever sees single 128-bit transactions.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_chunk_counter.sv | 41 ++++
 rtl/dma_xfer_sequencer.sv | 114 +++++++++++
 tb/tb_dma_xfer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer sequencer: one-hot state encoding
// and chunk geometry constants.
package dma_pkg;

    localparam int unsigned CHUNK_BYTES  = 16;
    localparam int unsigned CHUNK_SHIFT  = 4;
    localparam logic        DIR_DISK2MEM = 1'b1;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StFetch = 6'b000010,
        StReq   = 6'b000100,
        StStore = 6'b001000,
        StAdv   = 6'b010000,
        StFin   = 6'b100000
    } state_t;

endpackage

// File: rtl/dma_chunk_counter.sv
// Chunk address, disk-buffer index and remaining-chunk counter for one transfer.
module dma_chunk_counter #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [11:0]      load_addr,
    input  logic [CNT_W-1:0] load_cnt,
    output logic [11:0]      addr,
    output logic [7:0]       idx,
    output logic             last
);

    logic [11:0]      addr_q;
    logic [7:0]       idx_q;
    logic [CNT_W-1:0] rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
        end else if (load) begin
            addr_q <= load_addr;
            idx_q  <= '0;
            rem_q  <= load_cnt;
        end else if (step) begin
            // Address wraps modulo 64 KiB without complaint.
            addr_q <= addr_q + 12'd1;
            idx_q  <= idx_q + 8'd1;
            rem_q  <= rem_q - CNT_W'(1);
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;
    assign last = (rem_q == CNT_W'(1));

endmodule

// File: rtl/dma_xfer_sequencer.sv
// Splits one block-transfer command into 16-byte chunk requests for the bus
// controller, moving each chunk to or from the local disk buffer.
module dma_xfer_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned CHUNK_BYTES = 16,
    parameter int unsigned CNT_W       = 9
) (
    input  logic         BUS_CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         DIR,
    input  logic [15:0]  MEM_ADDR,
    input  logic [11:0]  XFER_SIZE,
    output logic         BUSY,
    output logic         DONE,
    output logic [7:0]   DISK_IDX,
    input  logic [127:0] DISK_RD_DATA,
    output logic [127:0] DISK_WR_DATA,
    output logic         DISK_WE,
    output logic         MOD_EN,
    output logic         MOD_WR,
    output logic [15:0]  MOD_A,
    output logic [127:0] MOD_WRITE_DATA,
    input  logic [127:0] MOD_READ_DATA,
    input  logic         MOD_R
);

    state_t       state_q, state_d;
    logic         dir_q;
    logic [127:0] wr_data_q;
    logic [127:0] rd_data_q;
    logic         load, step, last;
    logic [11:0]  chunk_addr;
    logic [7:0]   idx;
    logic [12:0]  size_round;
    logic [CNT_W-1:0] n_chunks;
    logic         unused_addr_lsbs;

    assign unused_addr_lsbs = ^MEM_ADDR[CHUNK_SHIFT-1:0];

    // Round the byte count up to whole chunks; 4095 bytes gives 256.
    assign size_round = {1'b0, XFER_SIZE} + 13'(CHUNK_BYTES - 1);
    assign n_chunks   = CNT_W'(size_round >> CHUNK_SHIFT);

    dma_chunk_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (BUS_CLK),
        .rst_n     (RST),
        .load      (load),
        .step      (step),
        .load_addr (MEM_ADDR[15:CHUNK_SHIFT]),
        .load_cnt  (n_chunks),
        .addr      (chunk_addr),
        .idx       (idx),
        .last      (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    load = 1'b1;
                    if (XFER_SIZE == 12'd0)        state_d = StFin;
                    else if (DIR == DIR_DISK2MEM)  state_d = StFetch;
                    else                           state_d = StReq;
                end
            end
            StFetch: state_d = StReq;
            StReq: begin
                if (MOD_R) state_d = (dir_q == DIR_DISK2MEM) ? StAdv : StStore;
            end
            StStore: state_d = StAdv;
            StAdv: begin
                step = 1'b1;
                if (last)                       state_d = StFin;
                else if (dir_q == DIR_DISK2MEM) state_d = StFetch;
                else                            state_d = StReq;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            wr_data_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) dir_q <= DIR;
            if (state_q == StFetch) wr_data_q <= DISK_RD_DATA;
            if (state_q == StReq && MOD_R && dir_q != DIR_DISK2MEM) rd_data_q <= MOD_READ_DATA;
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    assign BUSY           = (state_q != StIdle) && (state_q != StFin);
    assign DONE           = (state_q == StFin);
    assign MOD_EN         = (state_q == StReq);
    assign MOD_WR         = dir_q;
    assign MOD_A          = {chunk_addr, {CHUNK_SHIFT{1'b0}}};
    assign MOD_WRITE_DATA = wr_data_q;
    assign DISK_IDX       = idx;
    assign DISK_WE        = (state_q == StStore);
    assign DISK_WR_DATA   = rd_data_q;

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Scoreboard bench for dma_xfer_sequencer: expected chunk requests, disk writes
// and completions are queued at command issue and consumed by a monitor.
module tb_dma_xfer_sequencer;

    logic         BUS_CLK = 1'b0;
    logic         RST = 1'b0;
    logic         START = 1'b0;
    logic         DIR = 1'b0;
    logic [15:0]  MEM_ADDR = '0;
    logic [11:0]  XFER_SIZE = '0;
    logic         BUSY, DONE, DISK_WE, MOD_EN, MOD_WR;
    logic [7:0]   DISK_IDX;
    logic [127:0] DISK_RD_DATA, DISK_WR_DATA, MOD_WRITE_DATA;
    logic [127:0] MOD_READ_DATA = '0;
    logic [15:0]  MOD_A;
    logic         MOD_R = 1'b0;

    dma_xfer_sequencer dut (
        .BUS_CLK        (BUS_CLK),
        .RST            (RST),
        .START          (START),
        .DIR            (DIR),
        .MEM_ADDR       (MEM_ADDR),
        .XFER_SIZE      (XFER_SIZE),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .DISK_IDX       (DISK_IDX),
        .DISK_RD_DATA   (DISK_RD_DATA),
        .DISK_WR_DATA   (DISK_WR_DATA),
        .DISK_WE        (DISK_WE),
        .MOD_EN         (MOD_EN),
        .MOD_WR         (MOD_WR),
        .MOD_A          (MOD_A),
        .MOD_WRITE_DATA (MOD_WRITE_DATA),
        .MOD_READ_DATA  (MOD_READ_DATA),
        .MOD_R          (MOD_R)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Disk buffer is read-only here: contents are fixed for the whole run.
    logic [127:0] disk_mem [256];
    logic [127:0] bus_mem  [4096];
    assign DISK_RD_DATA = disk_mem[DISK_IDX];

    typedef struct packed {
        logic [15:0]  a;
        logic         wr;
        logic         chk_wd;
        logic [127:0] wd;
    } req_t;

    typedef struct packed {
        logic [7:0]   idx;
        logic [127:0] data;
    } dw_t;

    req_t exp_req[$];
    dw_t  exp_dw[$];
    int   exp_done[$];

    int n_checks = 0;
    int n_fail   = 0;
    int bus_delay = 0;
    bit spurious_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Reference model: each chunk is the next 16-byte-aligned address, wrapping at 64 KiB.
    task automatic issue(input bit dir, input logic [15:0] addr, input logic [11:0] size);
        int   n;
        int   base;
        req_t r;
        dw_t  d;
        n    = (int'(size) + 15) / 16;
        base = int'(addr[15:4]);
        for (int i = 0; i < n; i++) begin
            r.a      = 16'(((base + i) % 4096) * 16);
            r.wr     = dir;
            r.chk_wd = dir;
            r.wd     = dir ? disk_mem[i] : '0;
            exp_req.push_back(r);
            if (!dir) begin
                d.idx  = 8'(i);
                d.data = bus_mem[(base + i) % 4096];
                exp_dw.push_back(d);
            end
        end
        exp_done.push_back(n);
        @(negedge BUS_CLK);
        START     = 1'b1;
        DIR       = dir;
        MEM_ADDR  = addr;
        XFER_SIZE = size;
        @(posedge BUS_CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 20000 && exp_done.size() != 0; c++) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        @(negedge BUS_CLK);
        chk("xfer_complete", 128'(exp_done.size()), 128'd0);
        chk("requests_drained", 128'(exp_req.size()), 128'd0);
        chk("disk_writes_drained", 128'(exp_dw.size()), 128'd0);
        chk("busy_idle", BUSY, 1'b0);
    endtask

    task automatic wait_mod_en();
        int c;
        c = 0;
        while (!MOD_EN && c < 50) begin
            @(negedge BUS_CLK);
            c++;
        end
        chk("mod_en_seen", MOD_EN, 1'b1);
    endtask

    // Bus controller model: answers each request after bus_delay cycles.
    int wait_cnt = 0;
    bit spur_pend = 1'b0;
    initial begin
        forever begin
            @(negedge BUS_CLK);
            MOD_R = 1'b0;
            if (!RST) begin
                wait_cnt  = 0;
                spur_pend = 1'b0;
            end else if (MOD_EN) begin
                if (wait_cnt >= bus_delay) begin
                    MOD_R         = 1'b1;
                    MOD_READ_DATA = bus_mem[MOD_A[15:4]];
                    wait_cnt      = 0;
                    spur_pend     = spurious_en;
                end else begin
                    wait_cnt++;
                end
            end else if (spur_pend) begin
                MOD_R         = 1'b1;
                MOD_READ_DATA = '1;
                spur_pend     = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic         prev_en = 1'b0;
    logic         prev_done = 1'b0;
    logic [15:0]  prev_a = '0;
    logic         prev_wr = 1'b0;
    logic [127:0] prev_wd = '0;
    initial begin
        req_t r;
        dw_t  d;
        int   t;
        forever begin
            @(negedge BUS_CLK);
            if (RST) begin
                if (MOD_EN && !prev_en) begin
                    if (exp_req.size() == 0) unexpected("unexpected_request");
                    else begin
                        r = exp_req.pop_front();
                        chk("mod_a", MOD_A, r.a);
                        chk("mod_wr", MOD_WR, r.wr);
                        if (r.chk_wd) chk("mod_write_data", MOD_WRITE_DATA, r.wd);
                    end
                end
                if (MOD_EN && prev_en) begin
                    chk("mod_a_stable", MOD_A, prev_a);
                    chk("mod_wr_stable", MOD_WR, prev_wr);
                    chk("mod_wdata_stable", MOD_WRITE_DATA, prev_wd);
                end
                if (DISK_WE) begin
                    if (exp_dw.size() == 0) unexpected("unexpected_disk_write");
                    else begin
                        d = exp_dw.pop_front();
                        chk("disk_idx", DISK_IDX, d.idx);
                        chk("disk_wr_data", DISK_WR_DATA, d.data);
                    end
                end
                if (DONE) begin
                    if (exp_done.size() == 0) unexpected("unexpected_done");
                    else begin
                        t = exp_done.pop_front();
                        chk("requests_before_done", 128'(exp_req.size()), 128'd0);
                    end
                    chk("busy_low_at_done", BUSY, 1'b0);
                    chk("done_single_pulse", prev_done, 1'b0);
                end
            end
            prev_en   = MOD_EN;
            prev_done = DONE;
            prev_a    = MOD_A;
            prev_wr   = MOD_WR;
            prev_wd   = MOD_WRITE_DATA;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) disk_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4096; i++) bus_mem[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(negedge BUS_CLK);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_disk_we", DISK_WE, 1'b0);
        chk("rst_mod_en", MOD_EN, 1'b0);
        chk("rst_mod_wr", MOD_WR, 1'b0);
        chk("rst_mod_a", MOD_A, 16'h0);
        chk("rst_disk_idx", DISK_IDX, 8'h0);
        chk("rst_mod_wdata", MOD_WRITE_DATA, 128'h0);
        chk("rst_disk_wdata", DISK_WR_DATA, 128'h0);
        @(negedge BUS_CLK);
        RST = 1'b1;

        // Disk to memory, three full chunks, slow bus.
        bus_delay = 3;
        issue(1'b1, 16'h1000, 12'd48);
        chk("busy_after_start", BUSY, 1'b1);
        chk("dir1_no_en_first_cycle", MOD_EN, 1'b0);
        @(posedge BUS_CLK);
        #1;
        chk("dir1_en_second_cycle", MOD_EN, 1'b1);
        wait_done();

        // Memory to disk, unaligned address and partial last chunk.
        bus_delay = 1;
        issue(1'b0, 16'h2008, 12'd17);
        chk("dir0_en_first_cycle", MOD_EN, 1'b1);
        wait_done();

        // Zero-length transfer.
        issue(1'b0, 16'h4440, 12'd0);
        chk("n0_done_next_cycle", DONE, 1'b1);
        chk("n0_busy_low", BUSY, 1'b0);
        wait_done();

        // Address wrap at the top of memory, both directions.
        issue(1'b1, 16'hFFF0, 12'd32);
        wait_done();
        issue(1'b0, 16'hFFE7, 12'd40);
        wait_done();

        // START during a transfer is ignored; spurious MOD_R after each chunk.
        bus_delay   = 2;
        spurious_en = 1'b1;
        issue(1'b1, 16'h3000, 12'd40);
        wait_mod_en();
        START     = 1'b1;
        DIR       = 1'b0;
        MEM_ADDR  = 16'h5550;
        XFER_SIZE = 12'd100;
        @(negedge BUS_CLK);
        START = 1'b0;
        wait_done();
        spurious_en = 1'b0;

        // Maximum transfer: 256 chunks, idx reaches 255.
        bus_delay = 0;
        issue(1'b0, 16'h8000, 12'd4095);
        wait_done();

        // Reset while a request is outstanding, then a fresh transfer.
        bus_delay = 3;
        issue(1'b0, 16'(($urandom % 4096) * 16), 12'd64);
        wait_mod_en();
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst_mod_en", MOD_EN, 1'b0);
        chk("async_rst_busy", BUSY, 1'b0);
        chk("async_rst_disk_we", DISK_WE, 1'b0);
        chk("async_rst_mod_a", MOD_A, 16'h0);
        exp_req.delete();
        exp_dw.delete();
        exp_done.delete();
        @(negedge BUS_CLK);
        @(negedge BUS_CLK);
        RST = 1'b1;
        issue(1'b1, 16'(($urandom % 4096) * 16), 12'd50);
        wait_done();

        for (int k = 0; k < 10; k++) begin
            bus_delay = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 1)), 16'($urandom), 12'($urandom_range(0, 300)));
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
